impact_sram_bist_driver: RTL

//  On-chip initiator for the IMPACT SRAM head's byte-wide pin interface: drives byte data, word/bank/byte

---
 rtl/impact_bist_pkg.sv | 47 ++++
 rtl/impact_bist_pattern_gen.sv | 31 +++
 rtl/impact_sram_bist_driver.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/impact_bist_pkg.sv
// Shared types and defaults for the IMPACT SRAM BIST driver.
// FSM state encoding, pattern mode codes, bank-walk helper functions.
package impact_bist_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WR_SETUP,
      ST_WR_STROBE,
      ST_WR_HOLD,
      ST_RD_SETUP,
      ST_RD_STROBE,
      ST_RD_WAIT,
      ST_RD_CMP,
      ST_DONE
   } bist_state_t;

   localparam logic [1:0] PAT_ZEROS = 2'b00;
   localparam logic [1:0] PAT_ONES  = 2'b01;
   localparam logic [1:0] PAT_CHECK = 2'b10;
   localparam logic [1:0] PAT_ADDR  = 2'b11;

   localparam int WORD_BITS_DEF = 10;
   localparam int RD_LAT_DEF    = 2;
   localparam int ERR_W_DEF     = 16;

   // Lowest enabled bank; 0 when the mask is empty.
   function automatic logic [1:0] first_bank(input logic [3:0] mask);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (mask[i]) r = 2'(i);
      end
      return r;
   endfunction

   // {found, bank}: lowest enabled bank strictly above cur.
   function automatic logic [2:0] next_bank(input logic [3:0] mask,
                                            input logic [1:0] cur);
      logic [2:0] r;
      r = {1'b0, cur};
      for (int i = 3; i >= 0; i--) begin
         if (i > int'(cur) && mask[i]) r = {1'b1, 2'(i)};
      end
      return r;
   endfunction

endpackage

// File: rtl/impact_bist_pattern_gen.sv
// Expected data byte for one SRAM location under a given pattern mode.
// Ports: mode, bank, word, byte_idx in; pattern (8 bits) out. Purely combinational.
module impact_bist_pattern_gen
   import impact_bist_pkg::*;
#(
   parameter int WORD_BITS = WORD_BITS_DEF
) (
   input  logic [1:0]           mode,
   input  logic [1:0]           bank,
   input  logic [WORD_BITS-1:0] word,
   input  logic [1:0]           byte_idx,
   output logic [7:0]           pattern
);

   logic [7:0] word8;

   // Low word bits, zero-extended for narrow arrays.
   assign word8 = 8'(word);

   always_comb begin
      pattern = 8'h00;
      unique case (mode)
         PAT_ZEROS: pattern = 8'h00;
         PAT_ONES:  pattern = 8'hFF;
         PAT_CHECK: pattern = (word[0] ^ byte_idx[0]) ? 8'hAA : 8'h55;
         PAT_ADDR:  pattern = word8 ^ {bank, byte_idx, 4'h0};
         default:   pattern = 8'h00;
      endcase
   end

endmodule

// File: rtl/impact_sram_bist_driver.sv
// Two-pass write/read-compare BIST initiator for the IMPACT SRAM byte-wide pin interface.
// Ports: wb_clk_i/wb_rst_i, start_i/abort_i/pat_mode_i/bank_mask_i control; head pins
// data_in_o, data_out_i, word/bank/byte_sel_o, write_en_o, read_en_o, sram_clk_o;
// status busy_o, done_o, pass_o, err_count_o (saturating).
// Optional IMPACT_BIST_FAILLOG_EN adds fail_valid_o/fail_addr_o/fail_data_o (first mismatch).
module impact_sram_bist_driver
   import impact_bist_pkg::*;
#(
   parameter int WORD_BITS = WORD_BITS_DEF,
   parameter int RD_LAT    = RD_LAT_DEF,
   parameter int ERR_W     = ERR_W_DEF
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [1:0]           pat_mode_i,
   input  logic [3:0]           bank_mask_i,
   output logic [7:0]           data_in_o,
   input  logic [7:0]           data_out_i,
   output logic [WORD_BITS-1:0] word_sel_o,
   output logic [1:0]           bank_sel_o,
   output logic [1:0]           byte_sel_o,
   output logic                 write_en_o,
   output logic                 read_en_o,
   output logic                 sram_clk_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 pass_o,
   output logic [ERR_W-1:0]     err_count_o
`ifdef IMPACT_BIST_FAILLOG_EN
   ,
   output logic                 fail_valid_o,
   output logic [WORD_BITS+3:0] fail_addr_o,
   output logic [7:0]           fail_data_o
`endif
);

   localparam int CW = $clog2(RD_LAT + 1);
   localparam logic [ERR_W-1:0] ERR_MAX = '1;

   bist_state_t          st;
   logic [1:0]           mode_q;
   logic [3:0]           mask_q;
   logic [CW-1:0]        wait_cnt;

   logic [2:0]           nb;
   logic                 last_byte;
   logic                 last_word;
   logic                 last_addr;
   logic [1:0]           adv_bank;
   logic [WORD_BITS-1:0] adv_word;
   logic [1:0]           adv_byte;

   logic [1:0]           g_mode;
   logic [1:0]           g_bank;
   logic [WORD_BITS-1:0] g_word;
   logic [1:0]           g_byte;
   logic [7:0]           wr_data;
   logic [7:0]           exp_byte;
   logic                 mism;
   logic                 idle_like;

   assign idle_like = (st == ST_IDLE) || (st == ST_DONE);
   assign mism      = (data_out_i != exp_byte);

   // Address walk: byte fastest, then word, then next enabled bank.
   always_comb begin
      nb        = next_bank(mask_q, bank_sel_o);
      last_byte = (byte_sel_o == 2'd3);
      last_word = (word_sel_o == '1);
      last_addr = last_byte && last_word && !nb[2];
      adv_byte  = byte_sel_o + 2'd1;
      adv_word  = word_sel_o;
      adv_bank  = bank_sel_o;
      if (last_byte) begin
         adv_word = word_sel_o + WORD_BITS'(1);
         if (last_word) adv_bank = nb[1:0];
      end
   end

   // Write data is generated for the location about to be set up;
   // from IDLE/DONE that is the first location of the new run.
   always_comb begin
      g_mode = mode_q;
      g_bank = adv_bank;
      g_word = adv_word;
      g_byte = adv_byte;
      if (idle_like) begin
         g_mode = pat_mode_i;
         g_bank = first_bank(bank_mask_i);
         g_word = '0;
         g_byte = 2'd0;
      end
   end

   impact_bist_pattern_gen #(.WORD_BITS(WORD_BITS)) u_wr_pat (
      .mode     (g_mode),
      .bank     (g_bank),
      .word     (g_word),
      .byte_idx (g_byte),
      .pattern  (wr_data)
   );

   impact_bist_pattern_gen #(.WORD_BITS(WORD_BITS)) u_rd_pat (
      .mode     (mode_q),
      .bank     (bank_sel_o),
      .word     (word_sel_o),
      .byte_idx (byte_sel_o),
      .pattern  (exp_byte)
   );

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         st          <= ST_IDLE;
         mode_q      <= 2'b00;
         mask_q      <= 4'h0;
         wait_cnt    <= '0;
         data_in_o   <= 8'h00;
         word_sel_o  <= '0;
         bank_sel_o  <= 2'd0;
         byte_sel_o  <= 2'd0;
         write_en_o  <= 1'b0;
         read_en_o   <= 1'b0;
         sram_clk_o  <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         pass_o      <= 1'b0;
         err_count_o <= '0;
`ifdef IMPACT_BIST_FAILLOG_EN
         fail_valid_o <= 1'b0;
         fail_addr_o  <= '0;
         fail_data_o  <= 8'h00;
`endif
      end else if (abort_i && busy_o) begin
         st         <= ST_IDLE;
         data_in_o  <= 8'h00;
         word_sel_o <= '0;
         bank_sel_o <= 2'd0;
         byte_sel_o <= 2'd0;
         write_en_o <= 1'b0;
         read_en_o  <= 1'b0;
         sram_clk_o <= 1'b0;
         busy_o     <= 1'b0;
      end else begin
         unique case (st)
            ST_IDLE, ST_DONE: begin
               if (start_i) begin
                  mode_q      <= pat_mode_i;
                  mask_q      <= bank_mask_i;
                  err_count_o <= '0;
`ifdef IMPACT_BIST_FAILLOG_EN
                  fail_valid_o <= 1'b0;
                  fail_addr_o  <= '0;
                  fail_data_o  <= 8'h00;
`endif
                  if (bank_mask_i == 4'h0) begin
                     st     <= ST_DONE;
                     done_o <= 1'b1;
                     pass_o <= 1'b1;
                  end else begin
                     st         <= ST_WR_SETUP;
                     done_o     <= 1'b0;
                     pass_o     <= 1'b0;
                     busy_o     <= 1'b1;
                     bank_sel_o <= g_bank;
                     word_sel_o <= '0;
                     byte_sel_o <= 2'd0;
                     data_in_o  <= wr_data;
                  end
               end
            end
            ST_WR_SETUP: begin
               st         <= ST_WR_STROBE;
               write_en_o <= 1'b1;
               sram_clk_o <= 1'b1;
            end
            ST_WR_STROBE: begin
               st         <= ST_WR_HOLD;
               sram_clk_o <= 1'b0;
            end
            ST_WR_HOLD: begin
               write_en_o <= 1'b0;
               if (last_addr) begin
                  st         <= ST_RD_SETUP;
                  bank_sel_o <= first_bank(mask_q);
                  word_sel_o <= '0;
                  byte_sel_o <= 2'd0;
                  data_in_o  <= 8'h00;
               end else begin
                  st         <= ST_WR_SETUP;
                  bank_sel_o <= adv_bank;
                  word_sel_o <= adv_word;
                  byte_sel_o <= adv_byte;
                  data_in_o  <= wr_data;
               end
            end
            ST_RD_SETUP: begin
               st         <= ST_RD_STROBE;
               read_en_o  <= 1'b1;
               sram_clk_o <= 1'b1;
            end
            ST_RD_STROBE: begin
               st         <= ST_RD_WAIT;
               sram_clk_o <= 1'b0;
               wait_cnt   <= '0;
            end
            ST_RD_WAIT: begin
               if (wait_cnt == CW'(RD_LAT - 1)) begin
                  st        <= ST_RD_CMP;
                  read_en_o <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            ST_RD_CMP: begin
               if (mism && err_count_o != ERR_MAX) begin
                  err_count_o <= err_count_o + ERR_W'(1);
               end
`ifdef IMPACT_BIST_FAILLOG_EN
               if (mism && !fail_valid_o) begin
                  fail_valid_o <= 1'b1;
                  fail_addr_o  <= {bank_sel_o, word_sel_o, byte_sel_o};
                  fail_data_o  <= data_out_i;
               end
`endif
               if (last_addr) begin
                  st         <= ST_DONE;
                  busy_o     <= 1'b0;
                  done_o     <= 1'b1;
                  pass_o     <= (err_count_o == '0) && !mism;
                  bank_sel_o <= 2'd0;
                  word_sel_o <= '0;
                  byte_sel_o <= 2'd0;
                  data_in_o  <= 8'h00;
               end else begin
                  st         <= ST_RD_SETUP;
                  bank_sel_o <= adv_bank;
                  word_sel_o <= adv_word;
                  byte_sel_o <= adv_byte;
               end
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

endmodule
